xadac_vload: RTL and testbench

XADAC_VLOAD -- requirements
Module: xadac_vload

---
 rtl/xadac_vload.sv | 165 ++++++++++++++++
 tb/tb_xadac_vload.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadac_vload.sv
// Vector load accelerator: turns exe requests into AXI reads and returns the read data as vd writes.
// Optional build macro XADAC_VLOAD_ZEROMASK_EN zeroes element lanes at or beyond the requested vlen.
module xadac_vload #(
  parameter int IdWidth      = 2,
  parameter int SbLen        = 2**IdWidth,
  parameter int SbDepth      = SbLen,
  parameter int AddrWidth    = 32,
  parameter int VecDataWidth = 64,
  parameter int ElemWidth    = 8,
  parameter int VecLenWidth  = 4,
  parameter int InstrWidth   = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    dec_req_valid,
  output logic                    dec_req_ready,
  input  logic [IdWidth-1:0]      dec_req_id,
  output logic                    dec_rsp_valid,
  input  logic                    dec_rsp_ready,
  output logic [IdWidth-1:0]      dec_rsp_id,
  output logic                    dec_rsp_accept,
  output logic [1:0]              dec_rsp_rs_read,
  output logic [2:0]              dec_rsp_vs_read,
  output logic                    dec_rsp_rd_clobber,
  output logic                    dec_rsp_vd_clobber,
  input  logic                    exe_req_valid,
  output logic                    exe_req_ready,
  input  logic [IdWidth-1:0]      exe_req_id,
  input  logic [InstrWidth-1:0]   exe_req_instr,
  input  logic [AddrWidth-1:0]    exe_req_rs_data0,
  output logic                    exe_rsp_valid,
  input  logic                    exe_rsp_ready,
  output logic [IdWidth-1:0]      exe_rsp_id,
  output logic [VecDataWidth-1:0] exe_rsp_vd_data,
  output logic                    exe_rsp_vd_write,
  output logic [IdWidth-1:0]      axi_ar_id,
  output logic [AddrWidth-1:0]    axi_ar_addr,
  output logic                    axi_ar_valid,
  input  logic                    axi_ar_ready,
  input  logic [IdWidth-1:0]      axi_r_id,
  input  logic [VecDataWidth-1:0] axi_r_data,
  input  logic                    axi_r_valid,
  output logic                    axi_r_ready
);

  localparam int Lanes = VecDataWidth / ElemWidth;

  logic [SbDepth-1:0][AddrWidth-1:0]    addr_q;
  logic [SbDepth-1:0][VecLenWidth-1:0]  vlen_q;
  logic [SbDepth-1:0][VecDataWidth-1:0] data_q;
  logic [SbDepth-1:0] req_done_q, ar_done_q, r_done_q, rsp_done_q;

  logic exe_fire, r_ok, rsp_fire, ar_load, rsp_load, ar_found, rsp_found;
  logic [SbDepth-1:0]      ar_pend, rsp_pend;
  logic [IdWidth-1:0]      ar_sel, rsp_sel;
  logic [AddrWidth-1:0]    ar_addr_sel;
  logic [VecDataWidth-1:0] r_data_m, rsp_data_sel;
  logic                    unused_instr;

  assign dec_rsp_valid      = dec_req_valid;
  assign dec_req_ready      = dec_rsp_valid && dec_rsp_ready;
  assign dec_rsp_id         = dec_req_id;
  assign dec_rsp_accept     = 1'b1;
  assign dec_rsp_rs_read    = 2'b01;
  assign dec_rsp_vs_read    = 3'b000;
  assign dec_rsp_rd_clobber = 1'b0;
  assign dec_rsp_vd_clobber = 1'b1;

  assign exe_req_ready = !req_done_q[exe_req_id];
  assign unused_instr  = ^{exe_req_instr[24:0], exe_req_instr[InstrWidth-1:25+VecLenWidth]};

`ifdef XADAC_VLOAD_ZEROMASK_EN
  function automatic logic [VecDataWidth-1:0] lane_mask(input logic [VecDataWidth-1:0] d,
                                                        input logic [VecLenWidth-1:0]  vl);
    logic [VecDataWidth-1:0] m;
    m = d;
    for (int i = 0; i < Lanes; i++) begin
      if (i >= int'(vl)) m[i*ElemWidth +: ElemWidth] = '0;
    end
    return m;
  endfunction
  assign r_data_m = lane_mask(axi_r_data, vlen_q[axi_r_id]);
`else
  logic unused_vlen;
  assign r_data_m    = axi_r_data;
  assign unused_vlen = ^{vlen_q, Lanes[0]};
`endif

  // Handshake decode plus lowest-id pick; a request or R beat landing this cycle is bypassed in.
  always_comb begin
    exe_fire  = exe_req_valid && exe_req_ready;
    r_ok      = axi_r_valid && axi_r_ready && ar_done_q[axi_r_id] && !r_done_q[axi_r_id];
    rsp_fire  = exe_rsp_valid && exe_rsp_ready;
    ar_load   = !axi_ar_valid || axi_ar_ready;
    rsp_load  = !exe_rsp_valid || exe_rsp_ready;
    ar_pend   = (req_done_q & ~ar_done_q) | (exe_fire ? (SbDepth'(1) << exe_req_id) : '0);
    rsp_pend  = (r_done_q & ~rsp_done_q) | (r_ok ? (SbDepth'(1) << axi_r_id) : '0);
    ar_found  = |ar_pend;
    rsp_found = |rsp_pend;
    ar_sel    = '0;
    rsp_sel   = '0;
    for (int i = SbDepth - 1; i >= 0; i--) begin
      ar_sel  = ar_pend[i]  ? IdWidth'(i) : ar_sel;
      rsp_sel = rsp_pend[i] ? IdWidth'(i) : rsp_sel;
    end
    ar_addr_sel  = (exe_fire && exe_req_id == ar_sel) ? exe_req_rs_data0 : addr_q[ar_sel];
    rsp_data_sel = (r_ok && axi_r_id == rsp_sel) ? r_data_m : data_q[rsp_sel];
  end

  // Scoreboard and registered AR / R / exe_rsp channels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q           <= '0;
      vlen_q           <= '0;
      data_q           <= '0;
      req_done_q       <= '0;
      ar_done_q        <= '0;
      r_done_q         <= '0;
      rsp_done_q       <= '0;
      axi_ar_valid     <= 1'b0;
      axi_ar_id        <= '0;
      axi_ar_addr      <= '0;
      axi_r_ready      <= 1'b0;
      exe_rsp_valid    <= 1'b0;
      exe_rsp_id       <= '0;
      exe_rsp_vd_data  <= '0;
      exe_rsp_vd_write <= 1'b0;
    end else begin
      axi_r_ready <= 1'b1;
      if (exe_fire) begin
        addr_q[exe_req_id]     <= exe_req_rs_data0;
        vlen_q[exe_req_id]     <= exe_req_instr[25 +: VecLenWidth];
        req_done_q[exe_req_id] <= 1'b1;
      end
      if (ar_load) begin
        axi_ar_valid <= ar_found;
        axi_ar_id    <= ar_found ? ar_sel : '0;
        axi_ar_addr  <= ar_found ? ar_addr_sel : '0;
        if (ar_found) ar_done_q[ar_sel] <= 1'b1;
      end
      if (r_ok) begin
        data_q[axi_r_id]   <= r_data_m;
        r_done_q[axi_r_id] <= 1'b1;
      end
      if (rsp_load) begin
        exe_rsp_valid    <= rsp_found;
        exe_rsp_id       <= rsp_found ? rsp_sel : '0;
        exe_rsp_vd_data  <= rsp_found ? rsp_data_sel : '0;
        exe_rsp_vd_write <= rsp_found;
        if (rsp_found) rsp_done_q[rsp_sel] <= 1'b1;
      end
      // The delivered entry can never be the target of any other update this cycle.
      if (rsp_fire) begin
        addr_q[exe_rsp_id]     <= '0;
        vlen_q[exe_rsp_id]     <= '0;
        data_q[exe_rsp_id]     <= '0;
        req_done_q[exe_rsp_id] <= 1'b0;
        ar_done_q[exe_rsp_id]  <= 1'b0;
        r_done_q[exe_rsp_id]   <= 1'b0;
        rsp_done_q[exe_rsp_id] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xadac_vload.sv
// Self-checking bench for xadac_vload: decode table, directed corner sequences, randomized scoreboard run.
module tb_xadac_vload;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dec_req_valid, dec_req_ready, dec_rsp_valid, dec_rsp_ready;
  logic [1:0]  dec_req_id, dec_rsp_id, dec_rsp_rs_read;
  logic        dec_rsp_accept, dec_rsp_rd_clobber, dec_rsp_vd_clobber;
  logic [2:0]  dec_rsp_vs_read;
  logic        exe_req_valid, exe_req_ready, exe_rsp_valid, exe_rsp_ready, exe_rsp_vd_write;
  logic [1:0]  exe_req_id, exe_rsp_id, axi_ar_id, axi_r_id;
  logic [31:0] exe_req_instr, exe_req_rs_data0, axi_ar_addr;
  logic [63:0] exe_rsp_vd_data, axi_r_data;
  logic        axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready;

  xadac_vload dut (
    .clk(clk), .rstn(rstn),
    .dec_req_valid(dec_req_valid), .dec_req_ready(dec_req_ready), .dec_req_id(dec_req_id),
    .dec_rsp_valid(dec_rsp_valid), .dec_rsp_ready(dec_rsp_ready), .dec_rsp_id(dec_rsp_id),
    .dec_rsp_accept(dec_rsp_accept), .dec_rsp_rs_read(dec_rsp_rs_read),
    .dec_rsp_vs_read(dec_rsp_vs_read), .dec_rsp_rd_clobber(dec_rsp_rd_clobber),
    .dec_rsp_vd_clobber(dec_rsp_vd_clobber),
    .exe_req_valid(exe_req_valid), .exe_req_ready(exe_req_ready), .exe_req_id(exe_req_id),
    .exe_req_instr(exe_req_instr), .exe_req_rs_data0(exe_req_rs_data0),
    .exe_rsp_valid(exe_rsp_valid), .exe_rsp_ready(exe_rsp_ready), .exe_rsp_id(exe_rsp_id),
    .exe_rsp_vd_data(exe_rsp_vd_data), .exe_rsp_vd_write(exe_rsp_vd_write),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid),
    .axi_r_ready(axi_r_ready)
  );

  always #5 clk = ~clk;

`ifdef XADAC_VLOAD_ZEROMASK_EN
  localparam bit ZeroMask = 1'b1;
`else
  localparam bit ZeroMask = 1'b0;
`endif

  typedef struct {
    logic       v;
    logic       rdy;
    logic [1:0] id;
    logic       exp_valid;
    logic       exp_ready;
    logic [7:0] exp_fields;
  } dec_vec_t;

  dec_vec_t    dv [4];
  int          checks = 0;
  int          errors = 0;
  int          st [4];       // 0 free, 1 requested, 2 AR done, 3 data returned
  logic [31:0] m_addr [4];
  int          m_vlen [4];
  logic [63:0] m_data [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Lanes of 8 bits below vl survive when masking is built in.
  function automatic logic [63:0] expect_data(input logic [63:0] d, input int vl);
    logic [63:0] keep;
    keep = (!ZeroMask || vl >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * vl)) - 64'd1);
    return d & keep;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctl"}, {axi_ar_valid, axi_ar_id, axi_ar_addr, axi_r_ready, exe_rsp_valid,
                           exe_rsp_id, exe_rsp_vd_write}, 64'd0);
    check({name, "_data"}, exe_rsp_vd_data, 64'd0);
  endtask

  task automatic exe(input logic [1:0] id, input logic [31:0] addr, input int vl);
    exe_req_valid    = 1'b1;
    exe_req_id       = id;
    exe_req_rs_data0 = addr;
    exe_req_instr    = 32'(vl) << 25;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0, d1, d2, d3;
    logic        ar_stall_p, rsp_stall_p, all_free;
    logic [1:0]  p_ar_id, p_rsp_id;
    logic [31:0] p_ar_addr;
    logic [63:0] p_rsp_data;
    int          pick, busy_cnt;

    rstn = 1'b0;
    dec_req_valid = 1'b0; dec_req_id = 2'd0; dec_rsp_ready = 1'b0;
    exe_req_valid = 1'b0; exe_req_id = 2'd0; exe_req_instr = 32'd0; exe_req_rs_data0 = 32'd0;
    exe_rsp_ready = 1'b0; axi_ar_ready = 1'b0;
    axi_r_valid = 1'b0; axi_r_id = 2'd0; axi_r_data = 64'd0;
    #2;
    check_idle("reset");
    @(negedge clk);
    rstn = 1'b1;
    next();
    check("r_ready_after_reset", axi_r_ready, 1'b1);

    // decode answers are combinational and fixed
    dv[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'hA1};
    dv[1] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 8'hA1};
    dv[2] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 8'hA1};
    dv[3] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'hA1};
    for (int i = 0; i < 4; i++) begin
      dec_req_valid = dv[i].v; dec_rsp_ready = dv[i].rdy; dec_req_id = dv[i].id;
      #1;
      check("dec_rsp_valid", dec_rsp_valid, dv[i].exp_valid);
      check("dec_req_ready", dec_req_ready, dv[i].exp_ready);
      check("dec_rsp_id", dec_rsp_id, dv[i].id);
      check("dec_fields", {dec_rsp_accept, dec_rsp_rs_read, dec_rsp_vs_read, dec_rsp_rd_clobber,
                           dec_rsp_vd_clobber}, dv[i].exp_fields);
    end
    dec_req_valid = 1'b0; dec_rsp_ready = 1'b0;
    next();

    // single load: AR latency, R to rsp latency, busy id
    exe(2'd0, 32'h1000, 4);
    axi_ar_ready = 1'b1;
    #1 check("exe_ready_free", exe_req_ready, 1'b1);
    next();
    exe_req_valid = 1'b0;
    check("ar_first", {axi_ar_valid, axi_ar_id, axi_ar_addr}, {1'b1, 2'd0, 32'h1000});
    #1 check("exe_ready_busy", exe_req_ready, 1'b0);
    next();
    check("ar_idle_after_hs", axi_ar_valid, 1'b0);
    axi_r_valid = 1'b1; axi_r_id = 2'd0; axi_r_data = 64'hFFFF_FFFF_FFFF_FFFF;
    next();
    axi_r_valid = 1'b0;
    check("rsp_first_ctl", {exe_rsp_valid, exe_rsp_id, exe_rsp_vd_write}, {1'b1, 2'd0, 1'b1});
    check("rsp_first_data", exe_rsp_vd_data, expect_data(64'hFFFF_FFFF_FFFF_FFFF, 4));
    exe_rsp_ready = 1'b1;
    #1 check("exe_ready_until_rsp", exe_req_ready, 1'b0);
    next();
    check("rsp_gone", exe_rsp_valid, 1'b0);
    #1 check("exe_ready_after_rsp", exe_req_ready, 1'b1);
    exe_rsp_ready = 1'b0;

    // AR ordering under a stall: id 0 stuck, then 2 and 1 requested
    axi_ar_ready = 1'b0;
    exe(2'd0, 32'h4000, 8);
    next();
    exe(2'd2, 32'h2000, 5);
    next();
    exe(2'd1, 32'h3000, 3);
    next();
    exe_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("ar_stall_hold", {axi_ar_valid, axi_ar_id, axi_ar_addr}, {1'b1, 2'd0, 32'h4000});
      next();
    end
    axi_ar_ready = 1'b1;
    next();
    check("ar_order_1", {axi_ar_valid, axi_ar_id, axi_ar_addr}, {1'b1, 2'd1, 32'h3000});
    next();
    check("ar_order_2", {axi_ar_valid, axi_ar_id, axi_ar_addr}, {1'b1, 2'd2, 32'h2000});
    next();
    check("ar_order_done", axi_ar_valid, 1'b0);

    // reversed R for ids 3 and 1 with exe_rsp back-pressure
    exe(2'd3, 32'h5000, 2);
    next();
    exe_req_valid = 1'b0;
    check("ar_id3", {axi_ar_valid, axi_ar_id, axi_ar_addr}, {1'b1, 2'd3, 32'h5000});
    next();
    d3 = 64'h1122_3344_5566_7788; d1 = 64'h99AA_BBCC_DDEE_FF00;
    d0 = 64'h0F1E_2D3C_4B5A_6978; d2 = 64'hCAFE_F00D_DEAD_BEEF;
    axi_r_valid = 1'b1; axi_r_id = 2'd3; axi_r_data = d3;
    next();
    axi_r_id = 2'd1; axi_r_data = d1;
    next();
    axi_r_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rsp_hold_ctl", {exe_rsp_valid, exe_rsp_id}, {1'b1, 2'd3});
      check("rsp_hold_data", exe_rsp_vd_data, expect_data(d3, 2));
      next();
    end
    exe_rsp_ready = 1'b1;
    next();
    check("rsp_second_ctl", {exe_rsp_valid, exe_rsp_id}, {1'b1, 2'd1});
    check("rsp_second_data", exe_rsp_vd_data, expect_data(d1, 3));
    next();
    check("rsp_both_done", exe_rsp_valid, 1'b0);
    exe_req_id = 2'd1;
    #1 check("id1_freed", exe_req_ready, 1'b1);
    exe_req_id = 2'd3;
    #1 check("id3_freed", exe_req_ready, 1'b1);
    axi_r_valid = 1'b1; axi_r_id = 2'd0; axi_r_data = d0;
    next();
    axi_r_id = 2'd2; axi_r_data = d2;
    check("rsp_id0_data", {exe_rsp_valid, exe_rsp_id, exe_rsp_vd_data}, {1'b1, 2'd0, expect_data(d0, 8)});
    next();
    axi_r_valid = 1'b0;
    check("rsp_id2_data", {exe_rsp_valid, exe_rsp_id, exe_rsp_vd_data}, {1'b1, 2'd2, expect_data(d2, 5)});
    next();
    check("rsp_drained", exe_rsp_valid, 1'b0);
    exe_rsp_ready = 1'b0;

    // reset with an AR outstanding, then a late R for that id
    axi_ar_ready = 1'b0;
    exe(2'd0, 32'h6000, 1);
    next();
    exe_req_valid = 1'b0;
    check("ar_before_reset", axi_ar_valid, 1'b1);
    #2 rstn = 1'b0;
    #1 check_idle("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    next();
    axi_r_valid = 1'b1; axi_r_id = 2'd0; axi_r_data = 64'hFFFF_FFFF_FFFF_FFFF;
    next();
    axi_r_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stale_r_dropped", {exe_rsp_valid, axi_ar_valid}, 2'b00);
      next();
    end
    exe_req_id = 2'd0;
    #1 check("id0_free_after_reset", exe_req_ready, 1'b1);

    // randomized traffic against a transaction-level scoreboard
    for (int i = 0; i < 4; i++) st[i] = 0;
    ar_stall_p = 1'b0; rsp_stall_p = 1'b0;
    p_ar_id = 2'd0; p_ar_addr = 32'd0; p_rsp_id = 2'd0; p_rsp_data = 64'd0;
    all_free = 1'b0;
    for (int cyc = 0; cyc < 1500 && !(cyc >= 600 && all_free); cyc++) begin
      @(posedge clk);
      #1;
      exe_req_valid    = (cyc < 600) && ($urandom_range(0, 1) == 1);
      exe_req_id       = 2'($urandom_range(0, 3));
      exe_req_rs_data0 = $urandom;
      exe_req_instr    = $urandom;
      axi_ar_ready     = ($urandom_range(0, 3) != 0);
      exe_rsp_ready    = ($urandom_range(0, 2) != 0);
      axi_r_valid      = 1'b0;
      axi_r_data       = {$urandom, $urandom};
      pick             = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (pick + k) % 4;
          if (!axi_r_valid && st[j] == 2) begin
            axi_r_valid = 1'b1;
            axi_r_id    = 2'(j);
          end
        end
      end else if ($urandom_range(0, 7) == 0 && (st[pick] == 0 || st[pick] == 3)) begin
        axi_r_valid = 1'b1;
        axi_r_id    = 2'(pick);
      end
      @(negedge clk);
      if (ar_stall_p)
        check("rnd_ar_hold", {axi_ar_valid, axi_ar_id, axi_ar_addr}, {1'b1, p_ar_id, p_ar_addr});
      if (rsp_stall_p)
        check("rnd_rsp_hold", {exe_rsp_valid, exe_rsp_id, exe_rsp_vd_data}, {1'b1, p_rsp_id, p_rsp_data});
      check("rnd_exe_ready", exe_req_ready, st[exe_req_id] == 0);
      check("rnd_r_ready", axi_r_ready, 1'b1);
      if (exe_rsp_valid && exe_rsp_ready) begin
        check("rnd_rsp_state", 64'(st[exe_rsp_id]), 64'd3);
        check("rnd_rsp_data", {exe_rsp_vd_write, exe_rsp_vd_data}, {1'b1, m_data[exe_rsp_id]});
        st[exe_rsp_id] = 0;
      end
      if (exe_req_valid && exe_req_ready) begin
        st[exe_req_id]     = 1;
        m_addr[exe_req_id] = exe_req_rs_data0;
        m_vlen[exe_req_id] = int'(exe_req_instr[28:25]);
      end
      if (axi_ar_valid && axi_ar_ready) begin
        check("rnd_ar_state", 64'(st[axi_ar_id]), 64'd1);
        check("rnd_ar_addr", axi_ar_addr, m_addr[axi_ar_id]);
        st[axi_ar_id] = 2;
      end
      if (axi_r_valid && axi_r_ready && st[axi_r_id] == 2) begin
        m_data[axi_r_id] = expect_data(axi_r_data, m_vlen[axi_r_id]);
        st[axi_r_id]     = 3;
      end
      ar_stall_p  = axi_ar_valid && !axi_ar_ready;
      p_ar_id     = axi_ar_id;
      p_ar_addr   = axi_ar_addr;
      rsp_stall_p = exe_rsp_valid && !exe_rsp_ready;
      p_rsp_id    = exe_rsp_id;
      p_rsp_data  = exe_rsp_vd_data;
      all_free    = (st[0] == 0) && (st[1] == 0) && (st[2] == 0) && (st[3] == 0);
    end
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) busy_cnt += (st[i] != 0) ? 1 : 0;
    check("rnd_drain_all_free", 64'(busy_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
